latch_stim_tx: RTL

- Parallel-in, serial-out transmitter that drives a level-sensitive storage element such as the team's D latches and flip-flops.
- Accepts a parallel word on a load request and emits it LSB-first on `serial_out`.
- Drives a companion `enable_out` strobe. The strobe opens only after data has settled, so the downstream latch captures each bit cleanly.
- It is the synthesizable driver side of the latch data/enable interface and replaces hand-written `#delay` stimulus.

---
 rtl/latch_stim_pkg.sv | 18 +
 rtl/latch_stim_tx_bit_timer.sv | 31 +++
 rtl/latch_stim_tx.sv | 105 ++++++++++
 3 files changed

// File: rtl/latch_stim_pkg.sv
// Shared types and defaults for the latch_stim_tx serial stimulus transmitter.
package latch_stim_pkg;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_BIT_CYCLES = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Even parity over a word of up to 64 bits; narrower words are zero-extended by the caller.
    function automatic logic even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/latch_stim_tx_bit_timer.sv
// Per-bit cycle counter for latch_stim_tx: counts 0..BIT_CYCLES-1 and flags the period edges.
module bit_timer #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic first_cycle,
    output logic last_cycle
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] count;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign first_cycle = (count == '0);
    assign last_cycle  = (count == LAST);

endmodule

// File: rtl/latch_stim_tx.sv
// Parallel-in, LSB-first serial transmitter driving a latch data/enable pair.
// Optional even-parity bit after the data word when LATCH_STIM_TX_PARITY_EN is defined.
module latch_stim_tx
    import latch_stim_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load,
    output logic             ready,
    output logic             busy,
    output logic             serial_out,
    output logic             enable_out,
    output logic             done
);

`ifdef LATCH_STIM_TX_PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

    state_t                state, state_next;
    logic [FRAME_BITS-1:0] shreg;
    logic [FRAME_BITS-1:0] load_word;
    logic [BW-1:0]         bit_cnt;
    logic                  first_cycle, last_cycle;
    logic                  last_bit;

`ifdef LATCH_STIM_TX_PARITY_EN
    // Parity helper takes a 64-bit word, so parity frames support WIDTH <= 64.
    assign load_word = {even_parity(64'(data_in)), data_in};
`else
    assign load_word = data_in;
`endif

    assign last_bit = (bit_cnt == LAST_BIT);

    // Timer is held at zero outside SHIFT so each frame starts on cycle 0 of bit 0.
    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (state != SHIFT),
        .first_cycle(first_cycle),
        .last_cycle (last_cycle)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (state == IDLE && load) begin
            shreg   <= load_word;
            bit_cnt <= '0;
        end else if (state == SHIFT && last_cycle) begin
            shreg   <= shreg >> 1;
            bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        serial_out = 1'b0;
        enable_out = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                ready = 1'b1;
                if (load) state_next = SHIFT;
            end
            SHIFT: begin
                busy       = 1'b1;
                serial_out = shreg[0];
                // Cycle 0 of each bit is data setup; single-cycle bits strobe throughout.
                enable_out = (BIT_CYCLES == 1) || !first_cycle;
                if (last_cycle && last_bit) state_next = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
